// File: rtl/aexm_bpcu_pkg.sv
// Shared constants for the branch/PC unit with exception vectoring.
package aexm_bpcu_pkg;

  // EX-stage opcodes that matter to the PC unit
  localparam logic [5:0] OPC_BRU  = 6'o46;
  localparam logic [5:0] OPC_BRUI = 6'o56;
  localparam logic [5:0] OPC_BCC  = 6'o47;
  localparam logic [5:0] OPC_BCCI = 6'o57;
  localparam logic [5:0] OPC_RTD  = 6'o55;
  localparam logic [5:0] OPC_IMM  = 6'o54;

  // Conditional-branch codes carried in rRD[2:0]; 6 and 7 never branch
  localparam logic [2:0] CC_EQ = 3'd0;
  localparam logic [2:0] CC_NE = 3'd1;
  localparam logic [2:0] CC_LT = 3'd2;
  localparam logic [2:0] CC_LE = 3'd3;
  localparam logic [2:0] CC_GT = 3'd4;
  localparam logic [2:0] CC_GE = 3'd5;

  // Vector codes reported on rXCE
  localparam logic [1:0] XCE_NONE = 2'd0;
  localparam logic [1:0] XCE_INT  = 2'd1;
  localparam logic [1:0] XCE_EXC  = 2'd2;
  localparam logic [1:0] XCE_BRK  = 2'd3;

  // Vector-take FSM encoding
  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_PEND = 2'd1;
  localparam logic [1:0] ST_TAKE = 2'd2;

  // Vector entries are two words apart from the table base
  function automatic logic [29:0] vec_addr(input logic [29:0] base, input logic [1:0] code);
    return base + {27'd0, code, 1'b0};
  endfunction

endpackage

// File: rtl/aexm_bpcu_xce_if.sv
// EX-stage operands in, PC/vector state out, between the core and the PC unit.
interface aexm_bpcu_xce_if #(parameter int IW = 24);
  logic [5:0]    rOPC;
  logic [4:0]    rRD;
  logic [4:0]    rRA;
  logic [1:0]    rMXALT;
  logic [31:0]   rRESULT;
  logic [31:0]   rDWBDI;
  logic [31:0]   rREGA;
  logic          msr_ie;
  logic [2:0]    xce_req;

  logic          xce_ack;
  logic [1:0]    rXCE;
  logic [29:0]   rXPC;
  logic [IW-3:0] aexm_icache_cycle_addr;
  logic [IW-3:0] aexm_icache_precycle_addr;
  logic [29:0]   rPC;
  logic [29:0]   rPCLNK;
  logic          rBRA;
  logic          rDLY;
  logic          rATOM;

  modport master (
    output rOPC, rRD, rRA, rMXALT, rRESULT, rDWBDI, rREGA, msr_ie, xce_req,
    input  xce_ack, rXCE, rXPC, aexm_icache_cycle_addr, aexm_icache_precycle_addr,
           rPC, rPCLNK, rBRA, rDLY, rATOM
  );

  modport slave (
    input  rOPC, rRD, rRA, rMXALT, rRESULT, rDWBDI, rREGA, msr_ie, xce_req,
    output xce_ack, rXCE, rXPC, aexm_icache_cycle_addr, aexm_icache_precycle_addr,
           rPC, rPCLNK, rBRA, rDLY, rATOM
  );
endinterface

// File: rtl/aexm_bpcu_cond.sv
// Operand-A forwarding mux and conditional-branch evaluator.
module aexm_bpcu_cond
  import aexm_bpcu_pkg::*;
(
  input  logic [1:0]  mxalt,
  input  logic [31:0] result,
  input  logic [31:0] dwbdi,
  input  logic [31:0] rega,
  input  logic [2:0]  cc,
  output logic        taken
);

  logic [31:0] opa;
  logic        zero;
  logic        neg;

  // Pick the freshest copy of operand A, then test it against the condition
  always_comb begin
    case (mxalt)
      2'd2:    opa = dwbdi;
      2'd1:    opa = result;
      default: opa = rega;
    endcase
    zero = (opa == 32'd0);
    neg  = opa[31];
    case (cc)
      CC_EQ:   taken = zero;
      CC_NE:   taken = ~zero;
      CC_LT:   taken = neg;
      CC_LE:   taken = neg | zero;
      CC_GT:   taken = ~(neg | zero);
      CC_GE:   taken = ~neg;
      default: taken = 1'b0;
    endcase
  end

endmodule

// File: rtl/aexm_bpcu_xce.sv
// Branch/PC unit: fetch address generation, branch flags and vectored
// interrupt/exception/break entry at safe instruction borders.
module aexm_bpcu_xce
  import aexm_bpcu_pkg::*;
#(
  parameter int          IW    = 24,
  parameter logic [29:0] VBASE = 30'h0
) (
  input logic            gclk,
  input logic            grst,
  input logic            gena,
  aexm_bpcu_xce_if.slave bus
);

  logic [29:0] rIPC, xIPC, rPC, rPCLNK, rXPC;
  logic        rBRA, rDLY, rATOM;
  logic [1:0]  rXCE, state, state_nxt, code;
  logic [2:0]  pend, pend_nxt, elig, sel;
  logic        imm, bru, bcc, rtd, cc_taken;
  logic        bra_dec, dly_dec, atom_nxt, fire;

  // Bits of the EX fields that the PC unit has no use for
  logic unused_bits;
  assign unused_bits = ^{bus.rRD[3], bus.rRA[3:0], bus.rRESULT[1:0]};

  aexm_bpcu_cond u_cond (
    .mxalt  (bus.rMXALT),
    .result (bus.rRESULT),
    .dwbdi  (bus.rDWBDI),
    .rega   (bus.rREGA),
    .cc     (bus.rRD[2:0]),
    .taken  (cc_taken)
  );

  // Decode the EX instruction into branch, delay-slot and safe-border terms
  always_comb begin
    imm      = (bus.rOPC == OPC_IMM);
    bru      = (bus.rOPC == OPC_BRU) | (bus.rOPC == OPC_BRUI);
    bcc      = (bus.rOPC == OPC_BCC) | (bus.rOPC == OPC_BCCI);
    rtd      = (bus.rOPC == OPC_RTD);
    bra_dec  = bru | rtd | (bcc & cc_taken);
    dly_dec  = (bru & bus.rRA[4]) | (bcc & bus.rRD[4]) | rtd;
    // rBRA high means EX holds a slot instruction, never a border
    atom_nxt = ~imm & ~bra_dec & ~rBRA;
  end

  // Fixed priority break > exception > interrupt; interrupts wait for msr_ie
  always_comb begin
    elig = {pend[2], pend[1], pend[0] & bus.msr_ie};
    sel  = 3'b000;
    code = XCE_NONE;
    if (elig[2]) begin
      sel  = 3'b100;
      code = XCE_BRK;
    end else if (elig[1]) begin
      sel  = 3'b010;
      code = XCE_EXC;
    end else if (elig[0]) begin
      sel  = 3'b001;
      code = XCE_INT;
    end
  end

  // Take only when both the previous and current EX instruction are border-
  // safe, so an IMM prefix or a branch is never separated from its follower.
  assign fire = gena & (state == ST_PEND) & rATOM & atom_nxt & (|elig);

  // A request landing on the clearing cycle re-sets its own bit
  assign pend_nxt = (pend & ~(fire ? sel : 3'b000)) | bus.xce_req;

  // Next fetch: vector on take, branch target on a real branch, else sequential.
  // The rBRA raised by a vector take only flushes; fetch keeps running
  // sequentially from the vector rather than jumping to rRESULT.
  always_comb begin
    if (fire)
      xIPC = vec_addr(VBASE, code);
    else if (rBRA && (state != ST_TAKE))
      xIPC = bus.rRESULT[31:2];
    else
      xIPC = rIPC + 30'd1;
  end

  // Vector-take sequencing
  always_comb begin
    state_nxt = state;
    case (state)
      ST_IDLE: if (|elig) state_nxt = ST_PEND;
      ST_PEND: begin
        if (fire)        state_nxt = ST_TAKE;
        else if (~|elig) state_nxt = ST_IDLE;
      end
      ST_TAKE: state_nxt = (|elig) ? ST_PEND : ST_IDLE;
      default: state_nxt = ST_IDLE;
    endcase
  end

  // Pending latches run free of gena; everything else advances only when enabled
  always_ff @(posedge gclk) begin
    if (grst) begin
      rIPC   <= 30'd0;
      rPC    <= 30'd0;
      rPCLNK <= 30'd0;
      rXPC   <= 30'd0;
      rBRA   <= 1'b0;
      rDLY   <= 1'b0;
      rATOM  <= 1'b0;
      rXCE   <= XCE_NONE;
      pend   <= 3'b000;
      state  <= ST_IDLE;
    end else begin
      pend <= pend_nxt;
      if (gena) begin
        rIPC   <= xIPC;
        rPC    <= rIPC;
        rPCLNK <= rPC;
        rATOM  <= atom_nxt;
        state  <= state_nxt;
        if (fire) begin
          rBRA <= 1'b1;
          rDLY <= 1'b0;
          rXPC <= rPC;
          rXCE <= code;
        end else begin
          rBRA <= bra_dec & ~rBRA;
          rDLY <= dly_dec & ~rBRA;
        end
      end
    end
  end

  assign bus.xce_ack                   = gena & (state == ST_TAKE);
  assign bus.rXCE                      = rXCE;
  assign bus.rXPC                      = rXPC;
  assign bus.aexm_icache_cycle_addr    = rIPC[IW-3:0];
  assign bus.aexm_icache_precycle_addr = xIPC[IW-3:0];
  assign bus.rPC                       = rPC;
  assign bus.rPCLNK                    = rPCLNK;
  assign bus.rBRA                      = rBRA;
  assign bus.rDLY                      = rDLY;
  assign bus.rATOM                     = rATOM;

endmodule

// File: tb/tb_aexm_bpcu_xce.sv
// Directed bench for the branch/PC unit with vectored exceptions.
module tb_aexm_bpcu_xce;

  localparam logic [29:0] VB = 30'h100;

  logic gclk, grst, gena;
  int   n_cmp, n_err;

  aexm_bpcu_xce_if #(.IW(24)) bus ();

  aexm_bpcu_xce #(.IW(24), .VBASE(VB)) dut (
    .gclk (gclk),
    .grst (grst),
    .gena (gena),
    .bus  (bus)
  );

  initial gclk = 1'b0;
  always #5 gclk = ~gclk;

  typedef struct {
    logic [5:0]  opc;
    logic [4:0]  rd;
    logic [4:0]  ra;
    logic [1:0]  mx;
    logic [31:0] rega;
    logic [31:0] dwbdi;
    logic [31:0] res;
    logic        bra;
    logic        dly;
  } vec_t;

  task automatic step();
    @(posedge gclk);
    #1;
  endtask

  task automatic set_nop();
    bus.rOPC = 6'd0; bus.rRD = 5'd0; bus.rRA = 5'd0; bus.rMXALT = 2'd0;
    bus.rRESULT = 32'd0; bus.rDWBDI = 32'd0; bus.rREGA = 32'd0;
  endtask

  task automatic quiet(input int n);
    set_nop();
    bus.xce_req = 3'b000;
    for (int i = 0; i < n; i++) step();
  endtask

  task automatic test_reset();
    set_nop(); bus.xce_req = 3'b000; bus.msr_ie = 1'b0;
    grst = 1'b1; gena = 1'b0;
    step(); step();
    #1;
    n_cmp++; if (bus.aexm_icache_cycle_addr !== 22'd0) begin n_err++; $display("FAIL reset.cycle_addr got %h exp 0", bus.aexm_icache_cycle_addr); end
    n_cmp++; if (bus.rPC !== 30'd0) begin n_err++; $display("FAIL reset.rPC got %h exp 0", bus.rPC); end
    n_cmp++; if (bus.rPCLNK !== 30'd0) begin n_err++; $display("FAIL reset.rPCLNK got %h exp 0", bus.rPCLNK); end
    n_cmp++; if (bus.rXPC !== 30'd0) begin n_err++; $display("FAIL reset.rXPC got %h exp 0", bus.rXPC); end
    n_cmp++; if ({bus.rBRA, bus.rDLY, bus.rATOM} !== 3'b000) begin n_err++; $display("FAIL reset.flags got %b exp 000", {bus.rBRA, bus.rDLY, bus.rATOM}); end
    n_cmp++; if (bus.rXCE !== 2'd0) begin n_err++; $display("FAIL reset.rXCE got %0d exp 0", bus.rXCE); end
    n_cmp++; if (bus.xce_ack !== 1'b0) begin n_err++; $display("FAIL reset.ack got %b exp 0", bus.xce_ack); end
    grst = 1'b0; gena = 1'b1;
    step();
    n_cmp++; if (bus.aexm_icache_cycle_addr !== 22'd1) begin n_err++; $display("FAIL seq.addr1 got %h exp 1", bus.aexm_icache_cycle_addr); end
    n_cmp++; if (bus.rATOM !== 1'b1) begin n_err++; $display("FAIL seq.atom got %b exp 1", bus.rATOM); end
    step();
    n_cmp++; if (bus.rPC !== 30'd1 || bus.rPCLNK !== 30'd0) begin n_err++; $display("FAIL seq.pc got %h/%h exp 1/0", bus.rPC, bus.rPCLNK); end
  endtask

  task automatic test_beq();
    bus.rOPC = 6'o47; bus.rRD = 5'h10; bus.rMXALT = 2'd0; bus.rREGA = 32'd0; bus.rRESULT = 32'h100;
    step();
    n_cmp++; if ({bus.rBRA, bus.rDLY, bus.rATOM} !== 3'b110) begin n_err++; $display("FAIL beq.flags got %b exp 110", {bus.rBRA, bus.rDLY, bus.rATOM}); end
    // delay slot holds a branch: it must be squashed
    bus.rOPC = 6'o46; bus.rRD = 5'd0; bus.rRA = 5'h10;
    #1;
    n_cmp++; if (bus.aexm_icache_precycle_addr !== 22'h40) begin n_err++; $display("FAIL beq.precycle got %h exp 40", bus.aexm_icache_precycle_addr); end
    step();
    n_cmp++; if (bus.aexm_icache_cycle_addr !== 22'h40) begin n_err++; $display("FAIL beq.cycle got %h exp 40", bus.aexm_icache_cycle_addr); end
    n_cmp++; if ({bus.rBRA, bus.rDLY} !== 2'b00) begin n_err++; $display("FAIL beq.slot_squash got %b exp 00", {bus.rBRA, bus.rDLY}); end
  endtask

  task automatic test_bne();
    set_nop();
    bus.rOPC = 6'o47; bus.rRD = 5'h01; bus.rMXALT = 2'd2; bus.rDWBDI = 32'd0;
    bus.rREGA = 32'h5; bus.rRESULT = 32'h800;
    #1;
    n_cmp++; if (bus.aexm_icache_precycle_addr !== 22'h41) begin n_err++; $display("FAIL bne.precycle got %h exp 41", bus.aexm_icache_precycle_addr); end
    step();
    n_cmp++; if (bus.aexm_icache_cycle_addr !== 22'h41) begin n_err++; $display("FAIL bne.cycle got %h exp 41", bus.aexm_icache_cycle_addr); end
    n_cmp++; if ({bus.rBRA, bus.rDLY, bus.rATOM} !== 3'b001) begin n_err++; $display("FAIL bne.flags got %b exp 001", {bus.rBRA, bus.rDLY, bus.rATOM}); end
    set_nop();
  endtask

  task automatic test_branch_table();
    vec_t t [13];
    t[0]  = '{6'o47, 5'h02, 5'h00, 2'd0, 32'h8000_0000, 32'h0, 32'h0,   1'b1, 1'b0}; // BLT neg
    t[1]  = '{6'o47, 5'h13, 5'h00, 2'd0, 32'h0,         32'h0, 32'h0,   1'b1, 1'b1}; // BLED zero
    t[2]  = '{6'o47, 5'h14, 5'h00, 2'd0, 32'h0,         32'h0, 32'h0,   1'b0, 1'b1}; // BGTD zero: slot flag anyway
    t[3]  = '{6'o47, 5'h04, 5'h00, 2'd0, 32'h5,         32'h0, 32'h0,   1'b1, 1'b0}; // BGT pos
    t[4]  = '{6'o47, 5'h05, 5'h00, 2'd0, 32'hFFFF_FFFF, 32'h0, 32'h0,   1'b0, 1'b0}; // BGE neg
    t[5]  = '{6'o47, 5'h06, 5'h00, 2'd0, 32'h0,         32'h0, 32'h0,   1'b0, 1'b0}; // cc6
    t[6]  = '{6'o47, 5'h17, 5'h00, 2'd0, 32'h8000_0000, 32'h0, 32'h0,   1'b0, 1'b1}; // cc7
    t[7]  = '{6'o47, 5'h01, 5'h00, 2'd1, 32'h0,         32'h0, 32'h200, 1'b1, 1'b0}; // BNE fwd rRESULT
    t[8]  = '{6'o55, 5'h00, 5'h00, 2'd0, 32'h0,         32'h0, 32'h0,   1'b1, 1'b1}; // RTD
    t[9]  = '{6'o56, 5'h00, 5'h00, 2'd0, 32'h0,         32'h0, 32'h0,   1'b1, 1'b0}; // BRUI no delay
    t[10] = '{6'o54, 5'h00, 5'h00, 2'd0, 32'h0,         32'h0, 32'h0,   1'b0, 1'b0}; // IMM
    t[11] = '{6'o57, 5'h00, 5'h00, 2'd3, 32'h0,         32'h1, 32'h4,   1'b1, 1'b0}; // BEQI mx3 uses rREGA
    t[12] = '{6'o47, 5'h00, 5'h00, 2'd2, 32'h0,         32'h1, 32'h0,   1'b0, 1'b0}; // BEQ fwd rDWBDI
    for (int i = 0; i < 13; i++) begin
      bus.rOPC = t[i].opc; bus.rRD = t[i].rd; bus.rRA = t[i].ra; bus.rMXALT = t[i].mx;
      bus.rREGA = t[i].rega; bus.rDWBDI = t[i].dwbdi; bus.rRESULT = t[i].res;
      step();
      n_cmp++; if ({bus.rBRA, bus.rDLY} !== {t[i].bra, t[i].dly}) begin n_err++; $display("FAIL tbl[%0d].bra_dly got %b exp %b", i, {bus.rBRA, bus.rDLY}, {t[i].bra, t[i].dly}); end
      set_nop();
      step(); step();
    end
  endtask

  task automatic test_int_masked();
    int  acks;
    logic found;
    quiet(3);
    bus.msr_ie = 1'b0;
    bus.xce_req = 3'b001;
    step();
    bus.xce_req = 3'b000;
    acks = 0;
    for (int i = 0; i < 10; i++) begin #1; if (bus.xce_ack) acks++; step(); end
    n_cmp++; if (acks !== 0) begin n_err++; $display("FAIL int.masked_acks got %0d exp 0", acks); end
    bus.msr_ie = 1'b1;
    found = 1'b0;
    for (int i = 0; i < 20 && !found; i++) begin step(); #1; if (bus.xce_ack) found = 1'b1; end
    n_cmp++; if (found !== 1'b1) begin n_err++; $display("FAIL int.ack_seen got %b exp 1", found); end
    n_cmp++; if (bus.rXCE !== 2'd1) begin n_err++; $display("FAIL int.rXCE got %0d exp 1", bus.rXCE); end
    n_cmp++; if (bus.aexm_icache_cycle_addr !== 22'h102) begin n_err++; $display("FAIL int.vector got %h exp 102", bus.aexm_icache_cycle_addr); end
    n_cmp++; if ({bus.rBRA, bus.rDLY} !== 2'b10) begin n_err++; $display("FAIL int.flags got %b exp 10", {bus.rBRA, bus.rDLY}); end
    step();
    n_cmp++; if (bus.aexm_icache_cycle_addr !== 22'h103) begin n_err++; $display("FAIL int.after_vector got %h exp 103", bus.aexm_icache_cycle_addr); end
    acks = 0;
    for (int i = 0; i < 10; i++) begin #1; if (bus.xce_ack) acks++; step(); end
    n_cmp++; if (acks !== 0) begin n_err++; $display("FAIL int.extra_acks got %0d exp 0", acks); end
  endtask

  task automatic test_brk_exc();
    int          n;
    logic        prev;
    logic [1:0]  code [2];
    logic [21:0] addr [2];
    logic [21:0] nxt;
    quiet(3);
    bus.xce_req = 3'b110;
    step();
    bus.xce_req = 3'b000;
    n = 0; prev = 1'b0; nxt = '0;
    code[0] = '0; code[1] = '0; addr[0] = '0; addr[1] = '0;
    for (int i = 0; i < 40; i++) begin
      #1;
      if (prev) nxt = bus.aexm_icache_cycle_addr;
      prev = 1'b0;
      if (bus.xce_ack) begin
        if (n < 2) begin code[n] = bus.rXCE; addr[n] = bus.aexm_icache_cycle_addr; end
        n++;
        prev = 1'b1;
      end
      step();
    end
    n_cmp++; if (n !== 2) begin n_err++; $display("FAIL brkexc.acks got %0d exp 2", n); end
    n_cmp++; if (code[0] !== 2'd3 || addr[0] !== 22'h106) begin n_err++; $display("FAIL brkexc.first got %0d@%h exp 3@106", code[0], addr[0]); end
    n_cmp++; if (code[1] !== 2'd2 || addr[1] !== 22'h104) begin n_err++; $display("FAIL brkexc.second got %0d@%h exp 2@104", code[1], addr[1]); end
    n_cmp++; if (nxt !== 22'h105) begin n_err++; $display("FAIL brkexc.after got %h exp 105", nxt); end
  endtask

  task automatic test_defer();
    int          ack_k;
    logic [29:0] xpc;
    logic [1:0]  xce;
    logic [21:0] va, pre4;
    quiet(4);
    ack_k = -1; xpc = '0; xce = '0; va = '0; pre4 = '0;
    for (int k = 0; k < 15; k++) begin
      set_nop();
      bus.xce_req = 3'b000;
      if (k == 0) begin bus.rOPC = 6'o54; bus.xce_req = 3'b010; end
      if (k == 1) begin bus.rOPC = 6'o46; bus.rRA = 5'h10; bus.rRESULT = 32'h400; end
      if (k == 2) bus.rRESULT = 32'h400;
      #1;
      if (k == 4) pre4 = bus.aexm_icache_precycle_addr;
      if (bus.xce_ack && ack_k < 0) begin
        ack_k = k; xpc = bus.rXPC; xce = bus.rXCE; va = bus.aexm_icache_cycle_addr;
      end
      step();
    end
    set_nop();
    n_cmp++; if (ack_k !== 5) begin n_err++; $display("FAIL defer.ack_cycle got %0d exp 5", ack_k); end
    n_cmp++; if (pre4 !== 22'h104) begin n_err++; $display("FAIL defer.precycle got %h exp 104", pre4); end
    n_cmp++; if (xpc !== 30'h100) begin n_err++; $display("FAIL defer.rXPC got %h exp 100", xpc); end
    n_cmp++; if (xce !== 2'd2 || va !== 22'h104) begin n_err++; $display("FAIL defer.vector got %0d@%h exp 2@104", xce, va); end
  endtask

  task automatic test_stall_reset();
    int acks;
    set_nop(); bus.xce_req = 3'b000; bus.msr_ie = 1'b1;
    grst = 1'b1; step();
    grst = 1'b0; step();
    gena = 1'b0; bus.xce_req = 3'b001;
    step();
    bus.xce_req = 3'b000;
    #1;
    n_cmp++; if (bus.aexm_icache_cycle_addr !== 22'd1 || bus.rPC !== 30'd0) begin n_err++; $display("FAIL stall.hold got %h/%h exp 1/0", bus.aexm_icache_cycle_addr, bus.rPC); end
    n_cmp++; if (bus.xce_ack !== 1'b0) begin n_err++; $display("FAIL stall.ack got %b exp 0", bus.xce_ack); end
    step();
    gena = 1'b1; bus.rOPC = 6'o54;
    step();
    set_nop();
    grst = 1'b1;
    #1;
    n_cmp++; if (bus.xce_ack !== 1'b0) begin n_err++; $display("FAIL stall.pend_ack got %b exp 0", bus.xce_ack); end
    step();
    grst = 1'b0;
    #1;
    n_cmp++; if (bus.aexm_icache_cycle_addr !== 22'd0 || bus.rPC !== 30'd0 || bus.rPCLNK !== 30'd0) begin n_err++; $display("FAIL abort.pc got %h/%h/%h exp 0/0/0", bus.aexm_icache_cycle_addr, bus.rPC, bus.rPCLNK); end
    n_cmp++; if (bus.rXPC !== 30'd0 || bus.rXCE !== 2'd0) begin n_err++; $display("FAIL abort.xce got %h/%0d exp 0/0", bus.rXPC, bus.rXCE); end
    n_cmp++; if ({bus.rBRA, bus.rDLY, bus.rATOM, bus.xce_ack} !== 4'b0000) begin n_err++; $display("FAIL abort.flags got %b exp 0000", {bus.rBRA, bus.rDLY, bus.rATOM, bus.xce_ack}); end
    acks = 0;
    for (int i = 0; i < 10; i++) begin step(); #1; if (bus.xce_ack) acks++; end
    n_cmp++; if (acks !== 0) begin n_err++; $display("FAIL abort.acks got %0d exp 0", acks); end
  endtask

  initial begin
    n_cmp = 0; n_err = 0;
    grst = 1'b1; gena = 1'b1;
    bus.msr_ie = 1'b0; bus.xce_req = 3'b000;
    set_nop();
    test_reset();
    test_beq();
    test_bne();
    test_branch_table();
    test_int_masked();
    test_brk_exc();
    test_defer();
    test_stall_reset();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/aexm_bpcu_xce.md
AEXM_BPCU_XCE -- requirements
Module: aexm_bpcu_xce

Interface
REQ-001 Parameter IW, default 24, instruction-cache word-address width (byte-address bits IW-1:2).
REQ-002 Parameter VBASE, default 30'h0, word address of vector table base.
REQ-003 Port gclk  in  1  sole clock; all state SHALL update on rising edge.
REQ-004 Port grst  in  1  reset, synchronous, active-high.
REQ-005 Port gena  in  1  pipeline enable; low = stall.
REQ-006 Ports rOPC in 6, rRD in 5, rRA in 5  EX-stage opcode and register fields.
REQ-007 Ports rMXALT in 2, rRESULT in 32, rDWBDI in 32, rREGA in 32  operand-A forwarding select and sources.
REQ-008 Port msr_ie  in  1  interrupt enable.
REQ-009 Port xce_req  in  3  event pulses: bit0 interrupt, bit1 exception, bit2 break.
REQ-010 Port xce_ack  out  1  one-cycle pulse when a vector is taken.
REQ-011 Port rXCE  out  2  code of last vector taken (1 int, 2 exc, 3 brk).
REQ-012 Port rXPC  out  30  saved return word address.
REQ-013 Ports aexm_icache_cycle_addr, aexm_icache_precycle_addr  out  IW-2  registered/next fetch word address.
REQ-014 Ports rPC, rPCLNK  out  30  EX PC and link PC; rBRA, rDLY, rATOM  out  1  branch, delay-slot, safe-border flags.

Function
REQ-015 Operand A SHALL be rDWBDI when rMXALT=2, rRESULT when 1, else rREGA.
REQ-016 Opcodes SHALL decode: BRU 6'o46/6'o56, BCC 6'o47/6'o57, RTD 6'o55, IMM 6'o54.
REQ-017 BCC condition from rRD[2:0]: 0 EQ, 1 NE, 2 LT (bit31), 3 LE, 4 GT, 5 GE; codes 6,7 SHALL be not-taken.
REQ-018 Next rBRA SHALL be 1 for BRU/RTD, condition result for BCC, else 0; forced 0 when rBRA is 1.
REQ-019 Next rDLY SHALL be (BRU & rRA[4]) | (BCC & rRD[4]) | RTD; forced 0 when rBRA is 1.
REQ-020 Next fetch address SHALL be rRESULT[31:2] when rBRA, else rIPC+1, wrapping modulo 2^30.
REQ-021 rPC SHALL take previous rIPC; rPCLNK SHALL take previous rPC.
REQ-022 Safe border (rATOM) SHALL be 1 when EX holds no IMM, no taken branch, no RTD, and rBRA=0.
REQ-023 Each xce_req bit SHALL set a sticky pending latch, also while gena=0.
REQ-024 FSM states IDLE, PEND, TAKE: IDLE->PEND on any enabled pending; PEND->TAKE on gena & rATOM; TAKE->IDLE (or PEND if more pending) next enabled cycle.
REQ-025 Priority break > exception > interrupt; interrupt SHALL be eligible only while msr_ie=1, and remains pending otherwise.
REQ-026 On TAKE: next fetch address = VBASE + 2*code, rBRA=1, rDLY=0, rXPC=rPC, rXCE=code, xce_ack=1, chosen pending bit cleared.
REQ-027 A request arriving in the same cycle its latch is cleared SHALL remain pending.
REQ-028 With gena=0, all pipeline registers and FSM state SHALL hold; xce_ack SHALL be 0.
REQ-029 A vector take SHALL never split an IMM/branch and its delay slot.

Reset
REQ-030 On grst: rIPC, rPC, rPCLNK, rXPC = 0; rBRA, rDLY, rATOM, xce_ack = 0; rXCE = 0; pending = 0; FSM = IDLE.
REQ-031 grst SHALL override gena and abort any PEND/TAKE.

Structure
REQ-032 Package aexm_bpcu_pkg SHALL hold opcode constants, condition codes, vector codes, FSM state encoding.
REQ-033 Sub-module aexm_bpcu_cond SHALL implement the combinational condition evaluator (REQ-015, REQ-017).

Verification
REQ-034 BEQ (rOPC=6'o47, rRD=5'h10, rREGA=0, rRESULT=32'h100) -> rBRA=1, rDLY=1, fetch word 30'h40 next cycle.
REQ-035 BNE with rMXALT=2, rDWBDI=0 -> not taken, fetch increments by 1.
REQ-036 xce_req=3'b001, msr_ie=0 for 10 cycles, then msr_ie=1 at safe border -> ack once, fetch VBASE+2, rXCE=1.
REQ-037 xce_req=3'b110 together -> break taken first (VBASE+6), exception next (VBASE+4), two acks.
REQ-038 Exception during IMM then delayed branch -> take deferred until rATOM=1; rXPC = rPC at take.
REQ-039 Request pulse with gena=0, grst mid-PEND -> pending cleared, no ack, all outputs at reset values.
